// File: rtl/rob_multi_commit_pkg.sv
// Shared opcode space and helpers for the reorder buffer.
package rob_multi_commit_pkg;

    localparam int unsigned OP_LOG          = 6;
    localparam int unsigned ROB_LOG_DEFAULT = 4;

    localparam logic [OP_LOG-1:0] OP_NOP   = 6'd0;
    localparam logic [OP_LOG-1:0] OP_LUI   = 6'd1;
    localparam logic [OP_LOG-1:0] OP_AUIPC = 6'd2;
    localparam logic [OP_LOG-1:0] OP_JAL   = 6'd3;
    localparam logic [OP_LOG-1:0] OP_JALR  = 6'd4;
    localparam logic [OP_LOG-1:0] OP_BEQ   = 6'd5;
    localparam logic [OP_LOG-1:0] OP_BNE   = 6'd6;
    localparam logic [OP_LOG-1:0] OP_BLT   = 6'd7;
    localparam logic [OP_LOG-1:0] OP_BGE   = 6'd8;
    localparam logic [OP_LOG-1:0] OP_BLTU  = 6'd9;
    localparam logic [OP_LOG-1:0] OP_BGEU  = 6'd10;
    localparam logic [OP_LOG-1:0] OP_LB    = 6'd11;
    localparam logic [OP_LOG-1:0] OP_LH    = 6'd12;
    localparam logic [OP_LOG-1:0] OP_LW    = 6'd13;
    localparam logic [OP_LOG-1:0] OP_LBU   = 6'd14;
    localparam logic [OP_LOG-1:0] OP_LHU   = 6'd15;
    localparam logic [OP_LOG-1:0] OP_SB    = 6'd16;
    localparam logic [OP_LOG-1:0] OP_SH    = 6'd17;
    localparam logic [OP_LOG-1:0] OP_SW    = 6'd18;
    localparam logic [OP_LOG-1:0] OP_ADDI  = 6'd19;
    localparam logic [OP_LOG-1:0] OP_ADD   = 6'd28;
    localparam logic [OP_LOG-1:0] OP_SUB   = 6'd29;

    // Stores occupy a contiguous opcode range.
    function automatic logic is_store(logic [OP_LOG-1:0] op);
        return (op >= OP_SB) && (op <= OP_SW);
    endfunction

    // Conditional branches occupy a contiguous opcode range.
    function automatic logic is_branch(logic [OP_LOG-1:0] op);
        return (op >= OP_BEQ) && (op <= OP_BGEU);
    endfunction

endpackage

// File: rtl/rob_multi_commit_query.sv
// Operand query port: stored entry lookup with same-cycle write-back bypass.
module rob_query_port
    import rob_multi_commit_pkg::*;
#(
    parameter int unsigned ROB_LOG = ROB_LOG_DEFAULT,
    parameter int unsigned WB_CH   = 3
) (
    input  logic [ROB_LOG-1:0]                qry_id,
    input  logic [(2**ROB_LOG)-1:0]           ent_ready,
    input  logic [(2**ROB_LOG)-1:0][31:0]     ent_value,
    input  logic [WB_CH-1:0]                  wb_valid,
    input  logic [WB_CH*ROB_LOG-1:0]          wb_RobId,
    input  logic [WB_CH*32-1:0]               wb_value,
    output logic                              qry_ready,
    output logic [31:0]                       qry_value
);

    // Stored state first; a matching write-back in this cycle overrides it.
    always_comb begin
        qry_ready = ent_ready[qry_id];
        qry_value = ent_value[qry_id];
        for (int c = 0; c < WB_CH; c++) begin
            if (wb_valid[c] && (wb_RobId[c*ROB_LOG +: ROB_LOG] == qry_id)) begin
                qry_ready = 1'b1;
                qry_value = wb_value[c*32 +: 32];
            end
        end
    end

endmodule

// File: rtl/rob_multi_commit.sv
// Reorder buffer: in-order issue, multi-channel write-back, up to COMMIT_W retirements/cycle.
module rob_multi_commit
    import rob_multi_commit_pkg::*;
#(
    parameter int unsigned ROB_LOG  = ROB_LOG_DEFAULT,
    parameter int unsigned WB_CH    = 3,
    parameter int unsigned COMMIT_W = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rdy,
    input  logic                         issue_valid,
    input  logic [OP_LOG-1:0]            issue_op,
    input  logic [4:0]                   issue_dest,
    output logic [ROB_LOG-1:0]           rob_tail_id,
    output logic                         rob_full,
    output logic                         rob_next_full,
    input  logic [WB_CH-1:0]             wb_valid,
    input  logic [WB_CH*ROB_LOG-1:0]     wb_RobId,
    input  logic [WB_CH*32-1:0]          wb_value,
    input  logic [WB_CH-1:0]             wb_redirect,
    input  logic [WB_CH*32-1:0]          wb_toPC,
    input  logic [ROB_LOG-1:0]           qry_id_a,
    input  logic [ROB_LOG-1:0]           qry_id_b,
    output logic                         qry_ready_a,
    output logic                         qry_ready_b,
    output logic [31:0]                  qry_value_a,
    output logic [31:0]                  qry_value_b,
    output logic [COMMIT_W-1:0]          reg_enable,
    output logic [COMMIT_W*5-1:0]        reg_index,
    output logic [COMMIT_W*ROB_LOG-1:0]  reg_RobId,
    output logic [COMMIT_W*32-1:0]       reg_value,
    output logic                         store_req,
    output logic [ROB_LOG-1:0]           store_RobId,
    input  logic                         store_ack,
    output logic                         jump_flag,
    output logic [31:0]                  if_toPC,
    output logic [ROB_LOG:0]             rob_count
);

    localparam int unsigned DEPTH = 2**ROB_LOG;
    localparam int unsigned CW    = ROB_LOG + 1;
    localparam int unsigned RW    = $clog2(COMMIT_W + 1);

    logic [ROB_LOG-1:0]               head, tail;
    logic [CW-1:0]                    count;
    logic [DEPTH-1:0]                 ent_ready, ent_redirect;
    logic [DEPTH-1:0][OP_LOG-1:0]     ent_op;
    logic [DEPTH-1:0][4:0]            ent_dest;
    logic [DEPTH-1:0][31:0]           ent_value, ent_topc;

    logic                             issue_acc;
    logic [RW-1:0]                    retire_n;
    logic [COMMIT_W-1:0]              en_d;
    logic [COMMIT_W-1:0][ROB_LOG-1:0] slot_idx;
    logic                             jump_d, req_d;
    logic [31:0]                      topc_d;
    logic [ROB_LOG-1:0]               req_id_d;

    assign rob_tail_id   = tail;
    assign rob_count     = count;
    assign rob_full      = (count == CW'(DEPTH));
    assign rob_next_full = (count >= CW'(DEPTH - 1));
    assign issue_acc     = issue_valid && !rob_full;

    // In-order commit scan over head..head+COMMIT_W-1; stops at the first blocker.
    always_comb begin
        logic stop;
        stop     = 1'b0;
        retire_n = '0;
        en_d     = '0;
        slot_idx = '0;
        jump_d   = 1'b0;
        topc_d   = if_toPC;
        req_d    = 1'b0;
        req_id_d = store_RobId;
        for (int k = 0; k < COMMIT_W; k++) begin
            slot_idx[k] = head + ROB_LOG'(k);
            if (!stop) begin
                if ((CW'(k) >= count) || !ent_ready[slot_idx[k]]) begin
                    stop = 1'b1;
                end else if (is_store(ent_op[slot_idx[k]])) begin
                    // Stores only leave from slot 0, and only once the LSB acks.
                    stop = 1'b1;
                    if (k == 0) begin
                        if (store_req && store_ack) begin
                            retire_n = RW'(1);
                        end else begin
                            req_d    = 1'b1;
                            req_id_d = slot_idx[k];
                        end
                    end
                end else begin
                    retire_n = retire_n + RW'(1);
                    if (!is_branch(ent_op[slot_idx[k]])) en_d[k] = 1'b1;
                    if (ent_redirect[slot_idx[k]]) begin
                        jump_d = 1'b1;
                        topc_d = ent_topc[slot_idx[k]];
                        stop   = 1'b1;
                    end
                end
            end
        end
    end

    // Pointers, occupancy and per-entry status; a pending jump flushes everything.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            ent_ready    <= '0;
            ent_redirect <= '0;
        end else if (rdy) begin
            if (jump_flag) begin
                head         <= '0;
                tail         <= '0;
                count        <= '0;
                ent_ready    <= '0;
                ent_redirect <= '0;
            end else begin
                head  <= head + ROB_LOG'(retire_n);
                count <= count + CW'(issue_acc) - CW'(retire_n);
                if (issue_acc) begin
                    tail               <= tail + ROB_LOG'(1);
                    ent_ready[tail]    <= 1'b0;
                    ent_redirect[tail] <= 1'b0;
                end
                for (int c = 0; c < WB_CH; c++) begin
                    if (wb_valid[c]) begin
                        ent_ready[wb_RobId[c*ROB_LOG +: ROB_LOG]]    <= 1'b1;
                        ent_redirect[wb_RobId[c*ROB_LOG +: ROB_LOG]] <= wb_redirect[c];
                    end
                end
            end
        end
    end

    // Entry payload; no reset needed since ready bits gate every use.
    always_ff @(posedge clk) begin
        if (rst && rdy && !jump_flag) begin
            if (issue_acc) begin
                ent_op[tail]   <= issue_op;
                ent_dest[tail] <= issue_dest;
            end
            for (int c = 0; c < WB_CH; c++) begin
                if (wb_valid[c]) begin
                    ent_value[wb_RobId[c*ROB_LOG +: ROB_LOG]] <= wb_value[c*32 +: 32];
                    ent_topc[wb_RobId[c*ROB_LOG +: ROB_LOG]]  <= wb_toPC[c*32 +: 32];
                end
            end
        end
    end

    // Registered commit outputs; all hold while rdy is low.
    always_ff @(posedge clk) begin
        if (!rst) begin
            reg_enable  <= '0;
            reg_index   <= '0;
            reg_RobId   <= '0;
            reg_value   <= '0;
            store_req   <= 1'b0;
            store_RobId <= '0;
            jump_flag   <= 1'b0;
            if_toPC     <= '0;
        end else if (rdy) begin
            if (jump_flag) begin
                reg_enable <= '0;
                store_req  <= 1'b0;
                jump_flag  <= 1'b0;
                if_toPC    <= '0;
            end else begin
                reg_enable  <= en_d;
                store_req   <= req_d;
                store_RobId <= req_id_d;
                jump_flag   <= jump_d;
                if_toPC     <= topc_d;
                for (int k = 0; k < COMMIT_W; k++) begin
                    if (en_d[k]) begin
                        reg_index[k*5 +: 5]             <= ent_dest[slot_idx[k]];
                        reg_RobId[k*ROB_LOG +: ROB_LOG] <= slot_idx[k];
                        reg_value[k*32 +: 32]           <= ent_value[slot_idx[k]];
                    end
                end
            end
        end
    end

    rob_query_port #(.ROB_LOG(ROB_LOG), .WB_CH(WB_CH)) u_qry_a (
        .qry_id    (qry_id_a),
        .ent_ready (ent_ready),
        .ent_value (ent_value),
        .wb_valid  (wb_valid),
        .wb_RobId  (wb_RobId),
        .wb_value  (wb_value),
        .qry_ready (qry_ready_a),
        .qry_value (qry_value_a)
    );

    rob_query_port #(.ROB_LOG(ROB_LOG), .WB_CH(WB_CH)) u_qry_b (
        .qry_id    (qry_id_b),
        .ent_ready (ent_ready),
        .ent_value (ent_value),
        .wb_valid  (wb_valid),
        .wb_RobId  (wb_RobId),
        .wb_value  (wb_value),
        .qry_ready (qry_ready_b),
        .qry_value (qry_value_b)
    );

endmodule

// File: tb/tb_rob_multi_commit.sv
// Bench for rob_multi_commit: directed scenarios plus random traffic against a queue model.
module tb_rob_multi_commit;
    import rob_multi_commit_pkg::*;

    logic        clk, rst, rdy, issue_valid, store_ack;
    logic [5:0]  issue_op;
    logic [4:0]  issue_dest;
    logic [3:0]  rob_tail_id, qry_id_a, qry_id_b, store_RobId;
    logic        rob_full, rob_next_full, qry_ready_a, qry_ready_b, store_req, jump_flag;
    logic [2:0]  wb_valid, wb_redirect;
    logic [11:0] wb_RobId;
    logic [95:0] wb_value, wb_toPC;
    logic [31:0] qry_value_a, qry_value_b, if_toPC;
    logic [1:0]  reg_enable;
    logic [9:0]  reg_index;
    logic [7:0]  reg_RobId;
    logic [63:0] reg_value;
    logic [4:0]  rob_count;

    int errors = 0;
    int checks = 0;

    rob_multi_commit #(.ROB_LOG(4), .WB_CH(3), .COMMIT_W(2)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .issue_valid(issue_valid), .issue_op(issue_op),
        .issue_dest(issue_dest), .rob_tail_id(rob_tail_id), .rob_full(rob_full),
        .rob_next_full(rob_next_full), .wb_valid(wb_valid), .wb_RobId(wb_RobId),
        .wb_value(wb_value), .wb_redirect(wb_redirect), .wb_toPC(wb_toPC),
        .qry_id_a(qry_id_a), .qry_id_b(qry_id_b), .qry_ready_a(qry_ready_a),
        .qry_ready_b(qry_ready_b), .qry_value_a(qry_value_a), .qry_value_b(qry_value_b),
        .reg_enable(reg_enable), .reg_index(reg_index), .reg_RobId(reg_RobId),
        .reg_value(reg_value), .store_req(store_req), .store_RobId(store_RobId),
        .store_ack(store_ack), .jump_flag(jump_flag), .if_toPC(if_toPC), .rob_count(rob_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model: a queue of in-flight instructions ----------------
    typedef struct packed {
        logic [3:0]  id;
        logic [5:0]  op;
        logic [4:0]  dest;
        logic        ready;
        logic        redir;
        logic [31:0] val;
        logic [31:0] topc;
    } ent_t;

    ent_t        q[$];
    logic [3:0]  m_tail;
    logic [1:0]  m_en;
    logic [4:0]  m_idx[2];
    logic [31:0] m_val[2];
    logic [3:0]  m_id[2];
    logic        m_req, m_jump;
    logic [3:0]  m_req_id;
    logic [31:0] m_topc;

    function automatic bit op_store(logic [5:0] op);
        return op == OP_SB || op == OP_SH || op == OP_SW;
    endfunction

    function automatic bit op_branch(logic [5:0] op);
        return op == OP_BEQ || op == OP_BNE || op == OP_BLT || op == OP_BGE ||
               op == OP_BLTU || op == OP_BGEU;
    endfunction

    task automatic model_step();
        ent_t e;
        int   n;
        logic [1:0] en_n;
        logic req_n, jump_n;
        if (!rst) begin
            q.delete(); m_tail = 0; m_en = 0; m_req = 0; m_req_id = 0; m_jump = 0; m_topc = 0;
            for (int k = 0; k < 2; k++) begin m_idx[k] = 0; m_val[k] = 0; m_id[k] = 0; end
            return;
        end
        if (!rdy) return;
        if (m_jump) begin
            q.delete(); m_tail = 0; m_en = 0; m_req = 0; m_jump = 0; m_topc = 0;
            return;
        end
        n = 0; en_n = 0; req_n = 0; jump_n = 0;
        for (int k = 0; k < 2; k++) begin
            if (k >= q.size()) break;
            e = q[k];
            if (!e.ready) break;
            if (op_store(e.op)) begin
                if (k == 0) begin
                    if (m_req && store_ack) n = 1;
                    else begin req_n = 1; m_req_id = e.id; end
                end
                break;
            end
            n++;
            if (!op_branch(e.op)) begin
                en_n[k] = 1; m_idx[k] = e.dest; m_val[k] = e.val; m_id[k] = e.id;
            end
            if (e.redir) begin jump_n = 1; m_topc = e.topc; break; end
        end
        m_en = en_n; m_req = req_n; m_jump = jump_n;
        for (int c = 0; c < 3; c++) begin
            if (wb_valid[c]) begin
                for (int i = 0; i < q.size(); i++) begin
                    e = q[i];
                    if (e.id == wb_RobId[c*4 +: 4]) begin
                        e.ready = 1; e.val = wb_value[c*32 +: 32];
                        e.redir = wb_redirect[c]; e.topc = wb_toPC[c*32 +: 32];
                        q[i] = e;
                    end
                end
            end
        end
        if (issue_valid && q.size() < 16) begin
            e = '0; e.id = m_tail; e.op = issue_op; e.dest = issue_dest;
            q.push_back(e);
            m_tail = m_tail + 4'd1;
        end
        repeat (n) void'(q.pop_front());
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1; rdy = 1; issue_valid = 0; issue_op = OP_NOP; issue_dest = 0;
        wb_valid = 0; wb_redirect = 0; wb_RobId = 0; wb_value = 0; wb_toPC = 0;
        store_ack = 0; qry_id_a = 0; qry_id_b = 0;
    endtask

    task automatic issue(logic [5:0] op, logic [4:0] dest);
        issue_valid = 1; issue_op = op; issue_dest = dest;
        tick();
        issue_valid = 0;
    endtask

    task automatic set_wb(int ch, logic [3:0] id, logic [31:0] v, logic r, logic [31:0] pc);
        wb_valid[ch] = 1; wb_RobId[ch*4 +: 4] = id; wb_value[ch*32 +: 32] = v;
        wb_redirect[ch] = r; wb_toPC[ch*32 +: 32] = pc;
    endtask

    task automatic do_reset();
        idle(); rst = 0; tick(); tick(); rst = 1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        checks += 6;
        if (rob_count !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", rob_count); end
        if (reg_enable !== 2'b00) begin errors++; $display("FAIL reset_reg_enable got=%b exp=00", reg_enable); end
        if (store_req !== 1'b0) begin errors++; $display("FAIL reset_store_req got=%b exp=0", store_req); end
        if (jump_flag !== 1'b0) begin errors++; $display("FAIL reset_jump got=%b exp=0", jump_flag); end
        if (rob_tail_id !== 4'd0) begin errors++; $display("FAIL reset_tail got=%0d exp=0", rob_tail_id); end
        if (rob_full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", rob_full); end
    endtask

    task automatic test_dual_commit();
        do_reset();
        issue(OP_ADD, 5'd1);
        issue(OP_ADD, 5'd2);
        set_wb(0, 4'd0, 32'd5, 0, 0); set_wb(1, 4'd1, 32'd7, 0, 0);
        tick(); wb_valid = 0;
        tick();
        checks += 4;
        if (reg_enable !== 2'b11) begin errors++; $display("FAIL dual_en got=%b exp=11", reg_enable); end
        if (reg_index !== {5'd2, 5'd1}) begin errors++; $display("FAIL dual_index got=%h exp=%h", reg_index, {5'd2, 5'd1}); end
        if (reg_value !== {32'd7, 32'd5}) begin errors++; $display("FAIL dual_value got=%h exp=%h", reg_value, {32'd7, 32'd5}); end
        if (rob_count !== 5'd0) begin errors++; $display("FAIL dual_count got=%0d exp=0", rob_count); end
    endtask

    task automatic test_mispredict();
        do_reset();
        issue(OP_BEQ, 5'd0);
        issue(OP_ADD, 5'd3);
        set_wb(0, 4'd0, 32'd0, 1, 32'h100); set_wb(1, 4'd1, 32'd9, 0, 0);
        tick(); wb_valid = 0; wb_redirect = 0;
        tick();
        checks += 4;
        if (jump_flag !== 1'b1) begin errors++; $display("FAIL misp_jump got=%b exp=1", jump_flag); end
        if (if_toPC !== 32'h100) begin errors++; $display("FAIL misp_pc got=%h exp=100", if_toPC); end
        if (reg_enable !== 2'b00) begin errors++; $display("FAIL misp_no_commit got=%b exp=00", reg_enable); end
        if (rob_count !== 5'd1) begin errors++; $display("FAIL misp_count got=%0d exp=1", rob_count); end
        tick();
        checks += 3;
        if (rob_count !== 5'd0) begin errors++; $display("FAIL flush_count got=%0d exp=0", rob_count); end
        if (rob_tail_id !== 4'd0) begin errors++; $display("FAIL flush_tail got=%0d exp=0", rob_tail_id); end
        if (jump_flag !== 1'b0) begin errors++; $display("FAIL flush_jump got=%b exp=0", jump_flag); end
    endtask

    task automatic test_store();
        do_reset();
        issue(OP_SW, 5'd0);
        issue(OP_ADD, 5'd5);
        set_wb(0, 4'd0, 32'd0, 0, 0); set_wb(1, 4'd1, 32'd3, 0, 0);
        tick(); wb_valid = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks += 3;
            if (store_req !== 1'b1 || store_RobId !== 4'd0) begin
                errors++; $display("FAIL store_hold cyc=%0d got=%b/%0d exp=1/0", i, store_req, store_RobId);
            end
            if (reg_enable !== 2'b00) begin errors++; $display("FAIL store_block got=%b exp=00", reg_enable); end
            if (rob_count !== 5'd2) begin errors++; $display("FAIL store_wait_count got=%0d exp=2", rob_count); end
        end
        store_ack = 1; tick(); store_ack = 0;
        checks += 3;
        if (store_req !== 1'b0) begin errors++; $display("FAIL store_drop got=%b exp=0", store_req); end
        if (rob_count !== 5'd1) begin errors++; $display("FAIL store_retire got=%0d exp=1", rob_count); end
        if (reg_enable !== 2'b00) begin errors++; $display("FAIL store_no_reg got=%b exp=00", reg_enable); end
        tick();
        checks += 3;
        if (reg_enable !== 2'b01) begin errors++; $display("FAIL after_store_en got=%b exp=01", reg_enable); end
        if (reg_index[4:0] !== 5'd5 || reg_value[31:0] !== 32'd3) begin
            errors++; $display("FAIL after_store_data got=%0d/%0d exp=5/3", reg_index[4:0], reg_value[31:0]);
        end
        if (rob_count !== 5'd0) begin errors++; $display("FAIL after_store_count got=%0d exp=0", rob_count); end
    endtask

    task automatic test_full_wrap();
        do_reset();
        for (int i = 0; i < 15; i++) issue(OP_ADD, 5'(i + 1));
        checks += 2;
        if (rob_next_full !== 1'b1) begin errors++; $display("FAIL next_full got=%b exp=1", rob_next_full); end
        if (rob_full !== 1'b0) begin errors++; $display("FAIL early_full got=%b exp=0", rob_full); end
        issue(OP_ADD, 5'd16);
        checks += 3;
        if (rob_full !== 1'b1) begin errors++; $display("FAIL full got=%b exp=1", rob_full); end
        if (rob_count !== 5'd16) begin errors++; $display("FAIL full_count got=%0d exp=16", rob_count); end
        if (rob_tail_id !== 4'd0) begin errors++; $display("FAIL full_tail got=%0d exp=0", rob_tail_id); end
        issue(OP_ADD, 5'd17);
        checks += 2;
        if (rob_count !== 5'd16) begin errors++; $display("FAIL ignored_count got=%0d exp=16", rob_count); end
        if (rob_tail_id !== 4'd0) begin errors++; $display("FAIL ignored_tail got=%0d exp=0", rob_tail_id); end
        set_wb(0, 4'd0, 32'd11, 0, 0); set_wb(1, 4'd1, 32'd22, 0, 0);
        tick(); wb_valid = 0;
        tick();
        checks += 1;
        if (rob_count !== 5'd14) begin errors++; $display("FAIL retire2_count got=%0d exp=14", rob_count); end
        issue(OP_ADD, 5'd18);
        checks += 1;
        if (rob_tail_id !== 4'd1) begin errors++; $display("FAIL wrap_tail1 got=%0d exp=1", rob_tail_id); end
        issue(OP_ADD, 5'd19);
        checks += 2;
        if (rob_tail_id !== 4'd2) begin errors++; $display("FAIL wrap_tail2 got=%0d exp=2", rob_tail_id); end
        if (rob_count !== 5'd16) begin errors++; $display("FAIL wrap_count got=%0d exp=16", rob_count); end
        qry_id_a = 4'd15; qry_id_b = 4'd14;
        set_wb(2, 4'd15, 32'hDEAD, 0, 0);
        #1;
        checks += 3;
        if (qry_ready_a !== 1'b1) begin errors++; $display("FAIL byp_ready got=%b exp=1", qry_ready_a); end
        if (qry_value_a !== 32'hDEAD) begin errors++; $display("FAIL byp_value got=%h exp=dead", qry_value_a); end
        if (qry_ready_b !== 1'b0) begin errors++; $display("FAIL byp_other got=%b exp=0", qry_ready_b); end
        tick(); wb_valid = 0;
        #1;
        checks += 2;
        if (qry_ready_a !== 1'b1 || qry_value_a !== 32'hDEAD) begin
            errors++; $display("FAIL stored_query got=%b/%h exp=1/dead", qry_ready_a, qry_value_a);
        end
        if (rob_count !== 5'd16) begin errors++; $display("FAIL stuck_head_count got=%0d exp=16", rob_count); end
    endtask

    task automatic test_stall();
        do_reset();
        for (int i = 0; i < 4; i++) issue(OP_ADD, 5'(i + 8));
        set_wb(0, 4'd0, 32'd100, 0, 0); set_wb(1, 4'd1, 32'd101, 0, 0);
        set_wb(2, 4'd2, 32'd102, 0, 0);
        tick(); wb_valid = 0;
        set_wb(0, 4'd3, 32'd103, 0, 0);
        tick(); wb_valid = 0;
        rdy = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks += 2;
            if (reg_enable !== 2'b11 || reg_value !== {32'd101, 32'd100}) begin
                errors++; $display("FAIL stall_hold got=%b/%h exp=11/%h", reg_enable, reg_value, {32'd101, 32'd100});
            end
            if (rob_count !== 5'd2) begin errors++; $display("FAIL stall_count got=%0d exp=2", rob_count); end
        end
        rdy = 1;
        tick();
        checks += 3;
        if (reg_enable !== 2'b11) begin errors++; $display("FAIL resume_en got=%b exp=11", reg_enable); end
        if (reg_value !== {32'd103, 32'd102} || reg_index !== {5'd11, 5'd10}) begin
            errors++; $display("FAIL resume_data got=%h/%h", reg_value, reg_index);
        end
        if (rob_count !== 5'd0) begin errors++; $display("FAIL resume_count got=%0d exp=0", rob_count); end
    endtask

    task automatic test_random();
        logic [5:0] ops[9];
        ent_t e;
        int   ch;
        bit   found, byp, exp_r;
        logic [3:0]  qid;
        logic [31:0] exp_v, got_v;
        logic        got_r;
        ops = '{OP_ADD, OP_ADDI, OP_LW, OP_BEQ, OP_BNE, OP_BGEU, OP_SW, OP_SB, OP_JAL};
        do_reset();
        for (int it = 0; it < 1500; it++) begin
            rdy = ($urandom_range(0, 9) != 0);
            issue_valid = $urandom_range(0, 1);
            issue_op = ops[$urandom_range(0, 8)];
            issue_dest = 5'($urandom);
            wb_valid = 0; wb_redirect = 0;
            ch = 0;
            for (int i = 0; i < q.size() && ch < 3; i++) begin
                e = q[i];
                if (!e.ready && $urandom_range(0, 2) == 0) begin
                    set_wb(ch, e.id, $urandom, 0, $urandom & 32'hFFFF_FFFC);
                    if ((op_branch(e.op) || e.op == OP_JAL) && $urandom_range(0, 7) == 0)
                        wb_redirect[ch] = 1;
                    ch++;
                end
            end
            store_ack = m_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            qry_id_a = 4'($urandom);
            qry_id_b = (q.size() > 0) ? q[$urandom_range(0, q.size() - 1)].id : 4'd0;
            #1;
            for (int p = 0; p < 2; p++) begin
                qid = p ? qry_id_b : qry_id_a;
                got_r = p ? qry_ready_b : qry_ready_a;
                got_v = p ? qry_value_b : qry_value_a;
                found = 0; e = '0;
                foreach (q[i]) if (q[i].id == qid) begin found = 1; e = q[i]; end
                if (found) begin
                    byp = 0; exp_v = e.val;
                    for (int c = 0; c < 3; c++)
                        if (wb_valid[c] && wb_RobId[c*4 +: 4] == qid) begin
                            byp = 1; exp_v = wb_value[c*32 +: 32];
                        end
                    exp_r = e.ready || byp;
                    checks++;
                    if (got_r !== exp_r || (exp_r && got_v !== exp_v)) begin
                        errors++;
                        $display("FAIL rnd_query%0d it=%0d id=%0d got=%b/%h exp=%b/%h",
                                 p, it, qid, got_r, got_v, exp_r, exp_v);
                    end
                end
            end
            tick();
            checks += 6;
            if (rob_count !== 5'(q.size())) begin errors++; $display("FAIL rnd_count it=%0d got=%0d exp=%0d", it, rob_count, q.size()); end
            if (rob_tail_id !== m_tail) begin errors++; $display("FAIL rnd_tail it=%0d got=%0d exp=%0d", it, rob_tail_id, m_tail); end
            if (reg_enable !== m_en) begin errors++; $display("FAIL rnd_reg_en it=%0d got=%b exp=%b", it, reg_enable, m_en); end
            if (store_req !== m_req || (m_req && store_RobId !== m_req_id)) begin
                errors++; $display("FAIL rnd_store it=%0d got=%b/%0d exp=%b/%0d", it, store_req, store_RobId, m_req, m_req_id);
            end
            if (jump_flag !== m_jump) begin errors++; $display("FAIL rnd_jump it=%0d got=%b exp=%b", it, jump_flag, m_jump); end
            if (if_toPC !== m_topc) begin errors++; $display("FAIL rnd_pc it=%0d got=%h exp=%h", it, if_toPC, m_topc); end
            for (int k = 0; k < 2; k++) begin
                if (m_en[k]) begin
                    checks++;
                    if (reg_index[k*5 +: 5] !== m_idx[k] || reg_value[k*32 +: 32] !== m_val[k] ||
                        reg_RobId[k*4 +: 4] !== m_id[k]) begin
                        errors++;
                        $display("FAIL rnd_slot%0d it=%0d got=%0d/%h/%0d exp=%0d/%h/%0d", k, it,
                                 reg_index[k*5 +: 5], reg_value[k*32 +: 32], reg_RobId[k*4 +: 4],
                                 m_idx[k], m_val[k], m_id[k]);
                    end
                end
            end
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_dual_commit();
        test_mispredict();
        test_store();
        test_full_wrap();
        test_stall();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
